// File: rtl/rx_frame_sync_if.sv
// Bit-in / byte-out stream bundle for rx_frame_sync.
// The slave side is the synchroniser; the master side feeds bits and drains bytes.
interface rx_frame_sync_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/rx_frame_sync.sv
// Frame synchroniser: hunts a sync word with bounded bit errors, reads a length byte, emits payload bytes.
// Optional macro RX_FRAME_SYNC_INV_EN also accepts the bitwise-inverted sync and de-inverts the frame.
module rx_frame_sync #(
  parameter logic [31:0] SYNC_WORD = 32'h1ACFFC1D,
  parameter int          SYNC_LEN  = 32,
  parameter int          MAX_ERR   = 2
) (
  input  logic           clk,
  input  logic           rst,
  rx_frame_sync_if.slave bus,
  output logic           locked,
  output logic           sync_hit,
  output logic           inverted
);

  typedef enum logic [1:0] {HUNT, LEN, PAYLOAD} state_t;

  localparam logic [SYNC_LEN-1:0] PAT = SYNC_WORD[SYNC_LEN-1:0];
  localparam int                  FW  = $clog2(SYNC_LEN + 1);

  state_t              state;
  logic [SYNC_LEN-1:0] sr;
  logic [SYNC_LEN-1:0] sr_nxt;
  logic [FW-1:0]       fill;
  logic [FW-1:0]       fill_nxt;
  logic [2:0]          bit_cnt;
  logic [7:0]          byte_sr;
  logic [7:0]          byte_nxt;
  logic [7:0]          remaining;
  logic                accept;
  logic                bit_in;
  logic                full;
  logic                true_hit;
  logic                inv_hit;

  function automatic logic [5:0] popcount(input logic [SYNC_LEN-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < SYNC_LEN; i++) c = c + 6'(v[i]);
    return c;
  endfunction

  // Input stalls only when a finished byte is waiting on a blocked output register.
  assign bus.in_ready = !rst && (state != PAYLOAD || !bus.out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign sr_nxt       = {sr[SYNC_LEN-2:0], bus.in_data};
  assign fill_nxt     = (fill == FW'(SYNC_LEN)) ? fill : fill + 1'b1;
  assign full         = (fill_nxt == FW'(SYNC_LEN));
  assign bit_in       = bus.in_data ^ inverted;
  assign byte_nxt     = {byte_sr[6:0], bit_in};
  assign true_hit     = full && (popcount(sr_nxt ^ PAT) <= 6'(MAX_ERR));

`ifdef RX_FRAME_SYNC_INV_EN
  assign inv_hit = full && (popcount(~sr_nxt ^ PAT) <= 6'(MAX_ERR));
`else
  assign inv_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= HUNT;
      sr            <= '0;
      fill          <= '0;
      bit_cnt       <= '0;
      byte_sr       <= '0;
      remaining     <= '0;
      locked        <= 1'b0;
      sync_hit      <= 1'b0;
      inverted      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
    end else begin
      sync_hit <= 1'b0;
      if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;
      if (accept) begin
        sr <= sr_nxt;
        case (state)
          HUNT: begin
            fill <= fill_nxt;
            if (true_hit || inv_hit) begin
              // True polarity wins when both match.
              sync_hit <= 1'b1;
              inverted <= inv_hit && !true_hit;
              locked   <= 1'b1;
              bit_cnt  <= '0;
              state    <= LEN;
            end
          end
          LEN: begin
            byte_sr <= byte_nxt;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (byte_nxt == 8'd0) begin
                fill   <= '0;
                locked <= 1'b0;
                state  <= HUNT;
              end else begin
                remaining <= byte_nxt;
                state     <= PAYLOAD;
              end
            end
          end
          PAYLOAD: begin
            byte_sr <= byte_nxt;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              bus.out_data  <= byte_nxt;
              bus.out_valid <= 1'b1;
              bus.out_last  <= (remaining == 8'd1);
              remaining     <= remaining - 8'd1;
              if (remaining == 8'd1) begin
                fill   <= '0;
                locked <= 1'b0;
                state  <= HUNT;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_frame_sync.sv
// Self-checking bench for rx_frame_sync: table vectors, corner sequences, randomized streams vs a frame parser.
module tb_rx_frame_sync;

  localparam logic [31:0] SYNC_W = 32'h1ACFFC1D;
`ifdef RX_FRAME_SYNC_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic locked, sync_hit, inverted;

  rx_frame_sync_if bus();

  rx_frame_sync dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .locked   (locked),
    .sync_hit (sync_hit),
    .inverted (inverted)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  bit         stim[$];
  logic [9:0] exp_q[$];   // {inverted, last, data}
  logic [9:0] got_q[$];
  int         exp_hits;
  int         hits;
  bit         locked_seen;
  bit         chk_stall;
  int         rmode;
  int         cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errs++;
    $display("FAIL %s timed out", name);
  endtask

  // Output-side monitor and downstream ready pattern.
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready)
      got_q.push_back({inverted, bus.out_last, bus.out_data});
    if (sync_hit) hits++;
    if (locked) locked_seen = 1'b1;
    if (chk_stall && locked && bus.out_valid && !bus.out_ready)
      chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = (cyc % 3 == 0);
        2: bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
      cyc++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic push_byte(input logic [7:0] b, input logic inv);
    for (int i = 7; i >= 0; i--) stim.push_back(b[i] ^ inv);
  endtask

  task automatic push_word(input logic [31:0] w, input logic inv);
    for (int i = 31; i >= 0; i--) stim.push_back(w[i] ^ inv);
  endtask

  // Reference: scan the accepted bit sequence frame by frame.
  function automatic int ham(input int p, input logic inv);
    int d = 0;
    for (int k = 0; k < 32; k++)
      if ((stim[p - 31 + k] ^ inv) != SYNC_W[31 - k]) d++;
    return d;
  endfunction

  function automatic logic [7:0] get_byte(input int s, input logic inv);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[7 - k] = stim[s + k] ^ inv;
    return b;
  endfunction

  function automatic void build_model();
    int pos = 0;
    int p, s, n;
    bit found, done;
    logic inv;
    logic [7:0] len;
    exp_q.delete();
    exp_hits = 0;
    done = 0;
    while (!done) begin
      found = 0;
      inv = 0;
      for (p = pos + 31; p < stim.size(); p++) begin
        if (ham(p, 1'b0) <= 2) begin found = 1; inv = 0; break; end
        if (INV_EN && ham(p, 1'b1) <= 2) begin found = 1; inv = 1; break; end
      end
      if (!found) break;
      exp_hits++;
      s = p + 1;
      if (s + 8 > stim.size()) break;
      len = get_byte(s, inv);
      s += 8;
      n = int'(len);
      for (int k = 0; k < n; k++) begin
        if (s + 8 > stim.size()) begin done = 1; break; end
        exp_q.push_back({inv, (k == n - 1), get_byte(s, inv)});
        s += 8;
      end
      pos = s;
    end
  endfunction

  task automatic send_stim(input bit rnd);
    bit acc;
    int g;
    for (int i = 0; i < stim.size(); i++) begin
      if (rnd && ($urandom_range(0, 3) == 0)) begin
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = stim[i];
      g = 0;
      do begin
        @(negedge clk);
        acc = bus.in_ready;
        @(posedge clk);
        #1;
        g++;
      end while (!acc && g < 1000);
      if (!acc) begin
        timeout("bit_accept");
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_out", {bus.out_valid, bus.out_last, bus.out_data, locked, sync_hit, inverted}, 32'd0);
    got_q.delete();
    hits = 0;
    locked_seen = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int g = 0;
    while (got_q.size() < exp_q.size() && g < 3000) begin
      @(posedge clk);
      g++;
    end
    if (got_q.size() < exp_q.size()) timeout("drain");
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic compare_out(input string tag);
    chk({tag, "_nbytes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), {22'd0, got_q[i]}, {22'd0, exp_q[i]});
  endtask

  typedef struct {
    logic [31:0] sync;
    logic        inv_tx;
    logic [7:0]  len;
    logic [7:0]  pl [3];
    int          n_exp;
    logic [7:0]  ex [3];
    logic        inv_exp;
    int          hits_exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [31:0] w;
    logic        inv;
    logic [7:0]  len;
    int          np;

    bus.in_valid = 1'b0;
    bus.in_data  = 1'b0;
    chk_stall = 1'b0;
    rmode = 0;
    cyc = 0;

    vecs[0] = '{32'h1ACFFC1D, 1'b0, 8'h03, '{8'hA5, 8'h5A, 8'h7E}, 3, '{8'hA5, 8'h5A, 8'h7E}, 1'b0, 1};
    vecs[1] = '{32'h1ACFFC1E, 1'b0, 8'h03, '{8'hA5, 8'h5A, 8'h7E}, 3, '{8'hA5, 8'h5A, 8'h7E}, 1'b0, 1};
    vecs[2] = '{32'h1ACFFC1A, 1'b0, 8'h03, '{8'hA5, 8'h5A, 8'h7E}, 0, '{8'h00, 8'h00, 8'h00}, 1'b0, 0};
    if (INV_EN)
      vecs[3] = '{32'h1ACFFC1D, 1'b1, 8'h03, '{8'hA5, 8'h5A, 8'h7E}, 3, '{8'hA5, 8'h5A, 8'h7E}, 1'b1, 1};
    else
      vecs[3] = '{32'h1ACFFC1D, 1'b1, 8'h03, '{8'hA5, 8'h5A, 8'h7E}, 0, '{8'h00, 8'h00, 8'h00}, 1'b0, 0};
    vecs[4] = '{32'h9ACFFC1D, 1'b0, 8'h01, '{8'hFF, 8'h00, 8'h00}, 1, '{8'hFF, 8'h00, 8'h00}, 1'b0, 1};

    // Table vectors: one frame each, downstream always ready.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      stim.delete();
      push_word(vecs[v].sync, vecs[v].inv_tx);
      push_byte(vecs[v].len, vecs[v].inv_tx);
      for (int k = 0; k < int'(vecs[v].len) && k < 3; k++) push_byte(vecs[v].pl[k], vecs[v].inv_tx);
      exp_q.delete();
      for (int k = 0; k < vecs[v].n_exp; k++)
        exp_q.push_back({vecs[v].inv_exp, (k == vecs[v].n_exp - 1), vecs[v].ex[k]});
      rmode = 0;
      send_stim(1'b0);
      wait_drain();
      compare_out($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_hits", v), hits, vecs[v].hits_exp);
      chk($sformatf("vec%0d_locked_after", v), {31'd0, locked}, 32'd0);
      chk($sformatf("vec%0d_locked_seen", v), {31'd0, locked_seen}, {31'd0, (vecs[v].hits_exp > 0)});
    end

    // Zero-length frame, then a one-byte frame; output held back to observe latency.
    do_reset();
    stim.delete();
    push_word(SYNC_W, 1'b0);
    push_byte(8'h00, 1'b0);
    push_word(SYNC_W, 1'b0);
    push_byte(8'h01, 1'b0);
    push_byte(8'h3C, 1'b0);
    rmode = 3;
    @(posedge clk);
    #1;
    send_stim(1'b0);
    @(negedge clk);
    chk("len0_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("len0_out_data", {24'd0, bus.out_data}, 32'h3C);
    chk("len0_out_last", {31'd0, bus.out_last}, 32'd1);
    chk("len0_locked", {31'd0, locked}, 32'd0);
    chk("len0_hunt_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("len0_hits", hits, 2);
    exp_q.delete();
    exp_q.push_back({1'b0, 1'b1, 8'h3C});
    rmode = 0;
    wait_drain();
    compare_out("len0");

    // 16-byte frame under 1-of-3 ready: order, no loss, input stalls.
    do_reset();
    stim.delete();
    push_word(SYNC_W, 1'b0);
    rmode = 1;
    chk_stall = 1'b1;
    send_stim(1'b0);
    @(negedge clk);
    chk("sync_hit_pulse", {31'd0, sync_hit}, 32'd1);
    chk("sync_locked", {31'd0, locked}, 32'd1);
    @(posedge clk);
    #1;
    chk("sync_hit_one_cycle", {31'd0, sync_hit}, 32'd0);
    stim.delete();
    push_byte(8'h10, 1'b0);
    exp_q.delete();
    for (int k = 0; k < 16; k++) begin
      push_byte(8'(k), 1'b0);
      exp_q.push_back({1'b0, (k == 15), 8'(k)});
    end
    send_stim(1'b0);
    wait_drain();
    chk_stall = 1'b0;
    compare_out("bp16");

    // Reset in the middle of a 4-byte frame, then replay it whole.
    do_reset();
    rmode = 0;
    stim.delete();
    push_word(SYNC_W, 1'b0);
    push_byte(8'h04, 1'b0);
    push_byte(8'h11, 1'b0);
    push_byte(8'h22, 1'b0);
    for (int k = 0; k < 4; k++) stim.push_back(k[0]);
    send_stim(1'b0);
    chk("midrst_got", got_q.size(), 2);
    chk("midrst_pre_locked", {31'd0, locked}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_locked", {31'd0, locked}, 32'd0);
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    do_reset();
    stim.delete();
    push_word(SYNC_W, 1'b0);
    push_byte(8'h04, 1'b0);
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      push_byte(8'(8'h11 * (k + 1)), 1'b0);
      exp_q.push_back({1'b0, (k == 3), 8'(8'h11 * (k + 1))});
    end
    send_stim(1'b0);
    wait_drain();
    compare_out("replay");

    // Randomized streams: noise, bit errors, polarity, random valid/ready.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      stim.delete();
      for (int k = 0; k < int'($urandom_range(0, 40)); k++) stim.push_back(1'($urandom_range(0, 1)));
      for (int f = 0; f < 3; f++) begin
        w = SYNC_W;
        for (int e = 0; e < int'($urandom_range(0, 3)); e++) begin
          np = int'($urandom_range(0, 31));
          w[np] = ~w[np];
        end
        inv = 1'($urandom_range(0, 1));
        len = 8'($urandom_range(0, 6));
        push_word(w, inv);
        push_byte(len, inv);
        for (int k = 0; k < int'(len); k++) push_byte(8'($urandom), inv);
        for (int k = 0; k < int'($urandom_range(0, 20)); k++) stim.push_back(1'($urandom_range(0, 1)));
      end
      build_model();
      rmode = 2;
      send_stim(1'b1);
      rmode = 0;
      wait_drain();
      compare_out($sformatf("rand%0d", r));
      chk($sformatf("rand%0d_hits", r), hits, exp_hits);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
